serializer_fsm: RTL and testbench

SERIALIZER_FSM -- requirements
Module: serializer_fsm

---
 rtl/serializer_fsm.sv | 127 ++++++++++++
 tb/tb_serializer_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_fsm.sv
// serializer_fsm: takes LENGTH-bit words from an upstream FIR and sends them
// out one bit per transfer, LSB first, with a valid/ready handshake on the
// serial side. A one-deep hold register lets the next word wait while the
// current one shifts, so consecutive words leave with no gap cycle.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | nothing shifting; a held word is loaded on the next enabled edge
//   SHIFT_OUT | shift_q[0] presented on o_dout, advances on each transfer
module serializer_fsm #(
    parameter int LENGTH = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [LENGTH-1:0] iv_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic              o_dout,
    output logic              o_dout_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_busy
);

    localparam int CW = $clog2(LENGTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

    // Two-bit encoding so the unused codes have somewhere defined to go.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SHIFT_OUT = 2'b01
    } state_t;

    state_t            state_q, state_d;
    logic [LENGTH-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [LENGTH-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic accept;
    logic transfer;
    logic dout_valid;
    logic last_bit;

    // Output decode; o_ready drops with reset itself, not a clock later.
    always_comb begin
        dout_valid = (state_q == SHIFT_OUT);
        last_bit   = dout_valid && (cnt_q == CNT_LAST);
        o_ready    = !hold_valid_q && !i_rst;
        accept     = i_en && i_din_valid && o_ready;
        transfer   = i_en && dout_valid && i_ready;
    end

    assign o_dout_valid = dout_valid;
    assign o_dout       = dout_valid & shift_q[0];
    assign o_last       = last_bit;
    assign o_busy       = dout_valid || hold_valid_q;

    // Next-state logic: load/reload from the hold register, shift on transfer,
    // and capture new words into the hold register when it is empty.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_en && hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                if (transfer) begin
                    if (last_bit) begin
                        cnt_d = '0;
                        if (hold_valid_q) begin
                            // Back-to-back word: no return through IDLE.
                            shift_d      = hold_q;
                            hold_valid_d = 1'b0;
                        end else begin
                            shift_d = shift_q >> 1;
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // accept needs an empty hold register and a drain needs a full one,
        // so they never collide; a freshly drained register waits a cycle.
        if (accept) begin
            hold_d       = iv_din;
            hold_valid_d = 1'b1;
        end
    end

    // State and datapath registers; i_en low freezes everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
        end else if (i_en) begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serializer_fsm.sv
// Testbench for serializer_fsm: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level model of the word stream.
module tb_serializer_fsm;

    localparam int L = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [L-1:0] din;
    logic         din_valid;
    logic         rdy;
    logic         o_ready, o_dout, o_dout_valid, o_last, o_busy;

    int total = 0;
    int bad   = 0;

    // Reference model: a pending word slot, the word being sent and its bit index.
    logic [L-1:0] m_hold;
    bit           m_hold_full = 0;
    logic [L-1:0] m_cur;
    bit           m_active = 0;
    int           m_idx = 0;
    logic [L-1:0] exp_words[$];
    logic [L-1:0] asm_word;
    int           asm_cnt = 0;
    int           cur_run = 0;
    int           max_run = 0;

    serializer_fsm #(.LENGTH(L)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .iv_din       (din),
        .i_din_valid  (din_valid),
        .o_ready      (o_ready),
        .o_dout       (o_dout),
        .o_dout_valid (o_dout_valid),
        .i_ready      (rdy),
        .o_last       (o_last),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        logic acc, xfer, obs_d;
        logic [L-1:0] w;
        @(negedge clk);
        check_val("ready", o_ready, !m_hold_full);
        check_val("dout_valid", o_dout_valid, m_active);
        check_val("dout", o_dout, m_active ? m_cur[m_idx] : 1'b0);
        check_val("last", o_last, m_active && (m_idx == L - 1));
        check_val("busy", o_busy, m_active || m_hold_full);
        obs_d = o_dout;
        if (o_dout_valid) cur_run++;
        else cur_run = 0;
        if (cur_run > max_run) max_run = cur_run;
        @(posedge clk);
        acc  = en && din_valid && !m_hold_full;
        xfer = en && m_active && rdy;
        if (xfer) begin
            asm_word[asm_cnt] = obs_d;
            asm_cnt++;
            if (asm_cnt == L) begin
                asm_cnt = 0;
                if (exp_words.size() == 0) begin
                    check_val("word_extra", 32'(asm_word), 32'h0);
                end else begin
                    w = exp_words.pop_front();
                    check_val("word", 32'(asm_word), 32'(w));
                end
            end
        end
        if (en) begin
            if (xfer) begin
                if (m_idx == L - 1) begin
                    m_idx = 0;
                    if (m_hold_full) begin
                        m_cur       = m_hold;
                        m_hold_full = 0;
                    end else begin
                        m_active = 0;
                    end
                end else begin
                    m_idx++;
                end
            end else if (!m_active && m_hold_full) begin
                m_cur       = m_hold;
                m_hold_full = 0;
                m_idx       = 0;
                m_active    = 1;
            end
        end
        if (acc) begin
            m_hold      = din;
            m_hold_full = 1;
            exp_words.push_back(din);
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, o_ready, 1'b0);
        check_val({tag, "_dout"}, o_dout, 1'b0);
        check_val({tag, "_dv"}, o_dout_valid, 1'b0);
        check_val({tag, "_last"}, o_last, 1'b0);
        check_val({tag, "_busy"}, o_busy, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_now");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rst = 1'b0;
        #1;
        check_val("ready_after_rst", o_ready, 1'b1);
        m_hold_full = 0;
        m_active    = 0;
        m_idx       = 0;
        asm_cnt     = 0;
        exp_words.delete();
    endtask

    // Present a word until the model says it was taken, within max_cycles.
    task automatic offer(input logic [L-1:0] word, input int max_cycles);
        int  n;
        bit  taken = 0;
        din       = word;
        din_valid = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            n = exp_words.size();
            step();
            if (exp_words.size() > n) begin
                taken = 1;
                break;
            end
        end
        din_valid = 1'b0;
        if (!taken) check_val("offer_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        rdy       = 1'b1;
        do_reset();

        // Single word, continuous ready.
        offer(24'hA5F00F, 3);
        idle_steps(30);

        // Back-to-back words must stream without a gap.
        max_run = 0;
        cur_run = 0;
        offer(24'h000001, 3);
        offer(24'h800000, 5);
        idle_steps(55);
        check_val("run48", 32'(max_run), 32'd48);

        // Third word waits while the hold register is full.
        offer(24'h123ABC, 3);
        offer(24'h456DEF, 5);
        offer(24'h789012, 40);
        idle_steps(80);

        // Downstream stall mid-word.
        offer(24'h5A5A5A, 3);
        idle_steps(8);
        rdy = 1'b0;
        idle_steps(5);
        rdy = 1'b1;
        idle_steps(40);

        // Clock enable low mid-word with a word on offer.
        offer(24'hC3C3C3, 3);
        idle_steps(5);
        en        = 1'b0;
        din       = 24'hDEAD01;
        din_valid = 1'b1;
        idle_steps(3);
        en        = 1'b1;
        din_valid = 1'b0;
        idle_steps(40);

        // Reset during a word with another word held.
        offer(24'hFFFFFF, 3);
        step();
        offer(24'h0F0F0F, 3);
        idle_steps(10);
        do_reset();
        offer(24'h123456, 3);
        idle_steps(40);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            rdy       = ($urandom_range(0, 9) < 7);
            din_valid = ($urandom_range(0, 3) == 0);
            din       = L'($urandom);
            step();
        end

        en        = 1'b1;
        rdy       = 1'b1;
        din_valid = 1'b0;
        idle_steps(70);
        check_val("drained", 32'(exp_words.size()), 32'd0);
        check_val("final_busy", o_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
